// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with valid/ready handshakes on both sides.
// One quotient bit per cycle; signed operands are divided as magnitudes and fixed up afterwards.
module div_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             unsign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, dvs, rem, quo;
  logic             q_neg, r_neg;
  logic             accept, zero_div, ovf, qbit;
  logic [WIDTH:0]   rem_shift, trial;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] sv;
    sv = v;
    return neg ? -sv : sv;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign zero_div  = (b == '0);
  // Most-negative / -1 cannot be represented, so it bypasses the iteration.
  assign ovf       = !unsign && (a == MIN_NEG) && (b == '1);

  assign rem_shift = {rem, dvd[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs};
  assign qbit      = !trial[WIDTH];

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (zero_div || ovf) ? DONE : CALC;
      CALC: if (cnt == LAST) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= '0;
      else if (state == CALC)
        cnt <= cnt + CW'(1);
      // Result registers move only on entry into DONE so they stay stable under backpressure.
      if (accept && zero_div) begin
        quotient    <= '1;
        remainder   <= a;
        div_by_zero <= 1'b1;
      end else if (accept && ovf) begin
        quotient    <= a;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end else if (state == FIX) begin
        quotient    <= neg_if(quo, q_neg);
        remainder   <= neg_if(rem, r_neg);
        div_by_zero <= 1'b0;
      end
    end
  end

  // Working datapath: loaded on accept, then shifted once per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd   <= neg_if(a, !unsign && a[WIDTH-1]);
      dvs   <= neg_if(b, !unsign && b[WIDTH-1]);
      rem   <= '0;
      q_neg <= !unsign && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg <= !unsign && a[WIDTH-1];
    end else if (state == CALC) begin
      rem <= qbit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      quo <= {quo[WIDTH-2:0], qbit};
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter (WIDTH=8) against a plain-arithmetic reference model.
module tb_div_iter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, unsign, out_valid, out_ready, div_by_zero;
  logic [W-1:0] a, b, quotient, remainder;
  int           n_chk = 0;
  int           n_fail = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .unsign(unsign), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Truncating division with remainder taking the dividend's sign.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mu,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output logic sp);
    int sa, sb;
    z = 1'b0; sp = 1'b0;
    if (mb == 0) begin
      q = '1; r = ma; z = 1'b1; sp = 1'b1;
    end else if (!mu && ma == 8'h80 && mb == 8'hFF) begin
      q = ma; r = '0; sp = 1'b1;
    end else if (mu) begin
      q = ma / mb; r = ma % mb;
    end else begin
      sa = $signed(ma); sb = $signed(mb);
      q = 8'(sa / sb); r = 8'(sa % sb);
    end
  endfunction

  // Present operands for one accept edge; leaves time at #1 after that edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tu);
    check("in_ready_before_issue", int'(in_ready), 1);
    in_valid = 1'b1; a = ta; b = tb; unsign = tu;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); unsign = 1'($urandom);
  endtask

  // Counts edges from the accept edge (inclusive) to the first edge with out_valid high.
  task automatic await_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid_timeout", int'(out_valid), 1);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tu, input int lat);
    logic [W-1:0] eq, er;
    logic         ez, esp;
    model(ta, tb, tu, eq, er, ez, esp);
    check({tag, "_q"}, int'(quotient), int'(eq));
    check({tag, "_r"}, int'(remainder), int'(er));
    check({tag, "_dbz"}, int'(div_by_zero), int'(ez));
    check({tag, "_lat"}, lat, esp ? 1 : W + 2);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_back", int'(in_ready), 1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tu);
    int lat;
    issue(ta, tb, tu);
    await_result(lat);
    check_result(tag, ta, tb, tu, lat);
    consume();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    logic         ru;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; unsign = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_q", int'(quotient), 0);
    check("rst_r", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);

    run_op("u200_7", 8'hC8, 8'h07, 1'b1);
    run_op("s_m7_2", 8'hF9, 8'h02, 1'b0);
    run_op("s_7_m2", 8'h07, 8'hFE, 1'b0);
    run_op("dbz_u", 8'h25, 8'h00, 1'b1);
    run_op("dbz_s", 8'h25, 8'h00, 1'b0);
    run_op("ovf_s", 8'h80, 8'hFF, 1'b0);
    run_op("ovf_u", 8'h80, 8'hFF, 1'b1);

    // Backpressure, then consume with the next operands already waiting.
    issue(8'hC8, 8'h07, 1'b1);
    await_result(lat);
    check_result("bp", 8'hC8, 8'h07, 1'b1, lat);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_valid_hold", int'(out_valid), 1);
      check("bp_q_hold", int'(quotient), 'h1C);
      check("bp_r_hold", int'(remainder), 'h04);
      check("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h9C; b = 8'h05; unsign = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_consumed", int'(out_valid), 0);
    check("bp_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    check("bp_accepted", int'(in_ready), 0);
    await_result(lat);
    check_result("bp_second", 8'h9C, 8'h05, 1'b0, lat);
    consume();

    // Reset while iterating discards the operation.
    issue(8'hC8, 8'h07, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_q", int'(quotient), 0);
    check("mid_rst_r", int'(remainder), 0);
    check("mid_rst_dbz", int'(div_by_zero), 0);
    repeat (12) begin
      @(posedge clk); #1;
      check("mid_rst_no_result", int'(out_valid), 0);
    end
    run_op("after_rst", 8'h64, 8'h0A, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom);
      ru = 1'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 8'h00;
        1: begin ra = 8'h80; rb = 8'hFF; end
        2: rb = 8'($urandom_range(1, 3));
        3: rb = 8'hFF;
        default: rb = 8'($urandom);
      endcase
      run_op("rand", ra, rb, ru);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
